imem_load_ctrl: RTL

UART-driven instruction-memory load controller. It sits between the UART byte receiver and the instruction-memory write port. It parses a framed program image, writes it word by word into imem, and holds the fetch stage in its reset/hold state through `memcon_prog_ena` for the whole transfer. The core resumes from PC 0 only after an image has been written completely and its checksum has matched.

---
 rtl/imem_load_ctrl_if.sv | 31 +++
 rtl/imem_load_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl_if : UART byte input and imem write/status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface imem_load_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        memcon_prog_ena;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  modport master (
    output rx_valid, rx_data,
    input  memcon_prog_ena, imem_we, imem_waddr, imem_wdata,
           load_done, load_err, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data,
    output memcon_prog_ena, imem_we, imem_waddr, imem_wdata,
           load_done, load_err, words_loaded
  );
endinterface

`default_nettype wire

// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl : parses a UART program frame and writes it into imem
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_load_ctrl #(
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter int          MAX_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             Rst,
  imem_load_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0] MAXW     = 17'(MAX_WORDS);

  logic [2:0]    state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   asm_q, asm_d;
  logic [7:0]    xor_q, xor_d;
  logic [15:0]   words_q, words_d;
  logic          we_q, we_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          prog_q, prog_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          active;
  logic [15:0]   words_inc;

  assign active    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
  assign words_inc = words_q + 16'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    xor_d   = xor_q;
    words_d = words_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    prog_d  = prog_q;
    tmo_d   = '0;

    if (active) tmo_d = bus.rx_valid ? '0 : tmo_q + 1'b1;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.rx_valid && bus.rx_data == MAGIC) begin
          state_d = S_LEN_LO;
          prog_d  = 1'b1;
          err_d   = 1'b0;
          words_d = '0;
          xor_d   = '0;
          idx_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid) begin
          len_d   = {len_q[15:8], bus.rx_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (bus.rx_valid) begin
          len_d = {bus.rx_data, len_q[7:0]};
          if (len_d == 16'd0 || {1'b0, len_d} > MAXW) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          xor_d = xor_q ^ bus.rx_data;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    asm_d[7:0]   = bus.rx_data;
            2'd1:    asm_d[15:8]  = bus.rx_data;
            2'd2:    asm_d[23:16] = bus.rx_data;
            default: begin
              // Lane 3 completes the word; write and count land on the same edge.
              we_d    = 1'b1;
              wdata_d = {bus.rx_data, asm_q};
              waddr_d = BASE_ADDR + {14'd0, words_q, 2'b00};
              words_d = words_inc;
              if (words_inc == len_q) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            prog_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (active && !bus.rx_valid && tmo_q == TMO_LAST) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      xor_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      prog_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      xor_q   <= xor_d;
      words_q <= words_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      prog_q  <= prog_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.memcon_prog_ena = prog_q;
  assign bus.imem_we         = we_q;
  assign bus.imem_waddr      = waddr_q;
  assign bus.imem_wdata      = wdata_q;
  assign bus.load_done       = done_q;
  assign bus.load_err        = err_q;
  assign bus.words_loaded    = words_q;

endmodule

`default_nettype wire
